// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the clock monitor: FSM state encoding,
// error-counter width and a saturating increment.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ACQ     = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } state_t;

    localparam int ERR_W = 8;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        return (value == {ERR_W{1'b1}}) ? value : value + ERR_W'(1);
    endfunction

endpackage

// File: rtl/clock_monitor_if.sv
// Control and measurement bundle of the clock monitor. The master side drives
// the monitored clock and controls; the slave side is the monitor itself.
interface clock_monitor_if #(
    parameter int CNT_W = 16
);
    import clock_monitor_pkg::*;

    logic             enable;
    logic             mon_in;
    logic             err_clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             freq_ok;
    logic             clk_stopped;
    logic [ERR_W-1:0] err_count;

    modport master (
        output enable, mon_in, err_clr,
        input  period, high_time, period_valid, freq_ok, clk_stopped, err_count
    );

    modport slave (
        input  enable, mon_in, err_clr,
        output period, high_time, period_valid, freq_ok, clk_stopped, err_count
    );

endinterface

// File: rtl/clock_monitor_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus a one-cycle delayed
// copy, giving registered-source rise and fall strobes in the clk domain.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/clock_monitor.sv
// Clock-health monitor: measures period and high time of an asynchronous
// clock in clk cycles, flags out-of-range rates and stopped clocks.
//
// state   | meaning
// ACQ     | no valid reference rise yet; first rise only arms the monitor
// RUN     | reference rise held; next rise completes a period measurement
// STOPPED | no rise for STOP_TIMEOUT cycles; next rise re-arms without a result
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int MIN_PERIOD   = 4,
    parameter int MAX_PERIOD   = 16,
    parameter int STOP_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    clock_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] L_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] L_MIN_PERIOD = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] L_MAX_PERIOD = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] L_TIMEOUT_M1 = CNT_W'(STOP_TIMEOUT - 1);

    logic             w_s_unused;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_p1;
    logic             w_timeout;
    logic             w_in_range;
    logic             w_err_evt;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_period_valid;
    logic             r_freq_ok;
    logic             r_clk_stopped;
    logic [ERR_W-1:0] r_err_count;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.mon_in),
        .o_s     (w_s_unused),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // cnt never exceeds STOP_TIMEOUT-1 while in RUN, so cnt+1 cannot wrap there
    assign w_cnt_p1   = r_cnt + CNT_W'(1);
    assign w_timeout  = (r_cnt == L_TIMEOUT_M1);
    assign w_in_range = (w_cnt_p1 >= L_MIN_PERIOD) && (w_cnt_p1 <= L_MAX_PERIOD);
    assign w_err_evt  = (r_state == RUN) &&
                        ((w_rise && !w_in_range) || (!w_rise && w_timeout));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ACQ;
            r_cnt          <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_freq_ok      <= 1'b0;
            r_clk_stopped  <= 1'b0;
            r_err_count    <= '0;
        end else if (!bus.enable) begin
            r_state        <= ACQ;
            r_cnt          <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_freq_ok      <= 1'b0;
            r_clk_stopped  <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;

            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != L_CNT_MAX) begin
                r_cnt <= w_cnt_p1;
            end

            case (r_state)
                ACQ: begin
                    if (w_rise) begin
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        r_state       <= STOPPED;
                        r_clk_stopped <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_rise) begin
                        r_period       <= w_cnt_p1;
                        r_period_valid <= 1'b1;
                        r_freq_ok      <= w_in_range;
                    end else if (w_timeout) begin
                        r_state       <= STOPPED;
                        r_clk_stopped <= 1'b1;
                        r_freq_ok     <= 1'b0;
                    end
                    if (w_fall) begin
                        r_high_time <= w_cnt_p1;
                    end
                end
                STOPPED: begin
                    // first period after a restart is partial, so only re-arm
                    if (w_rise) begin
                        r_state       <= RUN;
                        r_clk_stopped <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ACQ;
                end
            endcase

            if (bus.err_clr) begin
                r_err_count <= w_err_evt ? ERR_W'(1) : '0;
            end else if (w_err_evt) begin
                r_err_count <= sat_inc(r_err_count);
            end
        end
    end

    assign bus.period       = r_period;
    assign bus.high_time    = r_high_time;
    assign bus.period_valid = r_period_valid;
    assign bus.freq_ok      = r_freq_ok;
    assign bus.clk_stopped  = r_clk_stopped;
    assign bus.err_count    = r_err_count;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: drives mon_in patterns cycle by cycle and
// checks measurements, stop detection, error counting, reset and enable.
module tb_clock_monitor;

    logic clk;
    logic reset;

    int n_assert;
    int n_fail;
    int step_idx;
    int pv_count;
    int first_pv_step;
    logic stop_seen;

    clock_monitor_if #(.CNT_W(16)) bus ();

    clock_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        step_idx      = 0;
        pv_count      = 0;
        first_pv_step = -1;
        stop_seen     = 1'b0;
    endtask

    // One clk cycle with mon_in held at m; outputs sampled 1 ns after the edge.
    task automatic clk_step(input logic m);
        bus.mon_in = m;
        @(posedge clk);
        #1;
        if (bus.period_valid) begin
            pv_count++;
            if (first_pv_step < 0) first_pv_step = step_idx;
        end
        if (bus.clk_stopped) stop_seen = 1'b1;
        step_idx++;
    endtask

    task automatic run_pattern(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) clk_step(1'b1);
            for (int i = 0; i < lo; i++) clk_step(1'b0);
        end
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.enable  = 1'b1;
        bus.err_clr = 1'b0;
        bus.mon_in  = 1'b0;
        reset_stats();

        // reset state
        repeat (3) clk_step(1'b0);
        check("rst_period",       32'(bus.period), 0);
        check("rst_high_time",    32'(bus.high_time), 0);
        check("rst_period_valid", 32'(bus.period_valid), 0);
        check("rst_freq_ok",      32'(bus.freq_ok), 0);
        check("rst_clk_stopped",  32'(bus.clk_stopped), 0);
        check("rst_err_count",    32'(bus.err_count), 0);
        reset = 1'b0;

        // 4 high / 4 low: first result after the second rise
        reset_stats();
        run_pattern(4, 4, 5);
        check("p8_first_pv_step", 32'(first_pv_step), 10);
        check("p8_pv_count",      32'(pv_count), 4);
        check("p8_period",        32'(bus.period), 8);
        check("p8_high_time",     32'(bus.high_time), 4);
        check("p8_freq_ok",       32'(bus.freq_ok), 1);
        check("p8_err_count",     32'(bus.err_count), 0);

        // 3 high / 17 low: too slow, one error per period after the first
        reset_stats();
        run_pattern(3, 17, 4);
        check("p20_pv_count",   32'(pv_count), 4);
        check("p20_period",     32'(bus.period), 20);
        check("p20_high_time",  32'(bus.high_time), 3);
        check("p20_freq_ok",    32'(bus.freq_ok), 0);
        check("p20_err_count",  32'(bus.err_count), 3);

        // period 8 then hold low: stop declared 64 cycles after last rise-detect
        reset_stats();
        run_pattern(4, 4, 3);
        check("pre_stop_freq_ok", 32'(bus.freq_ok), 1);
        check("pre_stop_err",     32'(bus.err_count), 4);
        for (int i = 0; i < 58; i++) clk_step(1'b0);
        check("stop_not_yet",     32'(bus.clk_stopped), 0);
        clk_step(1'b0);
        check("stop_asserted",    32'(bus.clk_stopped), 1);
        check("stop_freq_ok",     32'(bus.freq_ok), 0);
        check("stop_err_count",   32'(bus.err_count), 5);

        // restart: stop clears after the synchronizer delay, no partial result
        reset_stats();
        clk_step(1'b1);
        clk_step(1'b1);
        check("restart_still_stopped", 32'(bus.clk_stopped), 1);
        clk_step(1'b1);
        check("restart_cleared",       32'(bus.clk_stopped), 0);
        clk_step(1'b1);
        for (int i = 0; i < 4; i++) clk_step(1'b0);
        run_pattern(4, 4, 2);
        check("restart_first_pv_step", 32'(first_pv_step), 10);
        check("restart_pv_count",      32'(pv_count), 2);
        check("restart_period",        32'(bus.period), 8);
        check("restart_freq_ok",       32'(bus.freq_ok), 1);
        check("restart_err_count",     32'(bus.err_count), 5);

        // reset mid-period
        clk_step(1'b1);
        clk_step(1'b1);
        reset = 1'b1;
        clk_step(1'b1);
        reset = 1'b0;
        check("midrst_period",       32'(bus.period), 0);
        check("midrst_high_time",    32'(bus.high_time), 0);
        check("midrst_period_valid", 32'(bus.period_valid), 0);
        check("midrst_freq_ok",      32'(bus.freq_ok), 0);
        check("midrst_clk_stopped",  32'(bus.clk_stopped), 0);
        check("midrst_err_count",    32'(bus.err_count), 0);
        reset_stats();
        run_pattern(4, 4, 2);
        check("midrst_first_pv_step", 32'(first_pv_step), 10);
        check("midrst_period_after",  32'(bus.period), 8);

        // 1 high / 2 low: period 3, over 300 range errors saturate the count
        reset_stats();
        run_pattern(1, 2, 305);
        check("sat_pv_count",  32'(pv_count), 305);
        check("sat_period",    32'(bus.period), 3);
        check("sat_high_time", 32'(bus.high_time), 1);
        check("sat_err_count", 32'(bus.err_count), 255);
        for (int i = 0; i < 20; i++) clk_step(1'b0);
        check("sat_hold", 32'(bus.err_count), 255);
        bus.err_clr = 1'b1;
        clk_step(1'b0);
        bus.err_clr = 1'b0;
        check("clr_alone", 32'(bus.err_count), 0);
        // rise after >16 cycles is a range error; clear lands on that cycle
        clk_step(1'b1);
        clk_step(1'b1);
        bus.err_clr = 1'b1;
        clk_step(1'b1);
        bus.err_clr = 1'b0;
        check("clr_with_err", 32'(bus.err_count), 1);
        check("clr_with_err_freq_ok", 32'(bus.freq_ok), 0);
        for (int i = 0; i < 3; i++) clk_step(1'b0);

        // enable low while toggling
        bus.enable = 1'b0;
        clk_step(1'b0);
        check("dis_period",    32'(bus.period), 0);
        check("dis_high_time", 32'(bus.high_time), 0);
        check("dis_err_held",  32'(bus.err_count), 1);
        reset_stats();
        run_pattern(4, 4, 10);
        check("dis_pv_count",  32'(pv_count), 0);
        check("dis_stop_seen", 32'(stop_seen), 0);
        check("dis_freq_ok",   32'(bus.freq_ok), 0);
        check("dis_err_end",   32'(bus.err_count), 1);

        // re-enable behaves like a fresh start
        bus.enable = 1'b1;
        reset_stats();
        run_pattern(4, 4, 3);
        check("reen_first_pv_step", 32'(first_pv_step), 10);
        check("reen_pv_count",      32'(pv_count), 2);
        check("reen_period",        32'(bus.period), 8);
        check("reen_high_time",     32'(bus.high_time), 4);
        check("reen_freq_ok",       32'(bus.freq_ok), 1);
        check("reen_err_count",     32'(bus.err_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
